counter_seq: RTL and testbench
==============================

# counter_seq

Command-driven sequencer that sits directly upstream of the counter-IC clock/reset driver. It converts a "reset and/or advance N steps" command into correctly timed ADVANCE_COUNTER / RESET_COUNTER level requests, with programmable pulse and gap widths. It also keeps a mirror of the external counter position. The tester's top-level FSM issues commands through a valid/ready handshake and waits for DONE.

## Interface
- PULSE_CYCLES, 2: cycles ADVANCE_COUNTER is held high per step (≥1)
- GAP_CYCLES, 2: cycles both requests are held low after each pulse (≥1)
- RST_CYCLES, 4: cycles RESET_COUNTER is held high (≥1)
- COUNT_W, 16: width of step count and position mirror
- CLK  in  1  system clock (100 MHz)
- RST  in  1  reset, synchronous, active-high
- CMD_VALID  in  1  command present
- CMD_READY  out  1  block can accept a command
- CMD_RESET  in  1  reset the counters before stepping
- CMD_STEPS  in  COUNT_W  number of advance pulses
- ABORT  in  1  terminate the current command
- ADVANCE_COUNTER  out  1  advance request to the counter driver
- RESET_COUNTER  out  1  reset request to the counter driver
- BUSY  out  1  command in progress
- DONE  out  1  one-cycle completion pulse
- ABORTED  out  1  valid with DONE: the command was aborted
- POSITION  out  COUNT_W  mirror of the external counter value

## Operation
- States: IDLE, RST_PULSE, RST_GAP, ADV_PULSE, ADV_GAP, ABORT_GAP, FINISH.
- All outputs are registered. CMD_READY = (state==IDLE). BUSY = !CMD_READY && !DONE.
- Accept on CMD_VALID && CMD_READY. At acceptance, latch CMD_STEPS into `remaining` and latch CMD_RESET.
- On accept with CMD_RESET=1, go to RST_PULSE. Otherwise go to ADV_PULSE if steps≠0, else FINISH.
- RST_PULSE: RESET_COUNTER=1 for RST_CYCLES cycles, then RST_GAP.
- RST_GAP: GAP_CYCLES cycles with both requests low, then ADV_PULSE if remaining≠0, else FINISH.
- ADV_PULSE: ADVANCE_COUNTER=1 for PULSE_CYCLES cycles, then ADV_GAP. Decrement `remaining` on entry.
- ADV_GAP: GAP_CYCLES cycles with both requests low, then ADV_PULSE if remaining≠0, else FINISH.
- FINISH: DONE=1 for one cycle, then IDLE.
- ADVANCE_COUNTER and RESET_COUNTER are never high in the same cycle. The driver prioritises advance over reset, so overlap would corrupt a reset.
- POSITION update rules:
  - Cleared in the cycle RESET_COUNTER rises.
  - Incremented by 1 in the cycle ADVANCE_COUNTER rises.
  - Wraps modulo 2^COUNT_W (all-ones + 1 = 0).
- ABORT in any busy state other than FINISH (or ABORT_GAP, where it is ignored):
  - Both requests drop next cycle.
  - Go to ABORT_GAP for GAP_CYCLES cycles, then FINISH with ABORTED=1.
  - Pulses already started remain counted in POSITION.
- ABORT in IDLE is ignored. ABORT in FINISH is ignored.
- CMD_VALID while busy is ignored. Command fields are only sampled at acceptance.

## Timing
- Reset values:
  - CMD_READY=1
  - ADVANCE_COUNTER=0
  - RESET_COUNTER=0
  - BUSY=0
  - DONE=0
  - ABORTED=0
  - POSITION=0
  - state=IDLE
- RST mid-command returns to IDLE next cycle with requests low. POSITION=0. No DONE is emitted.
- With acceptance at edge 0, the first request is high in cycle 1.
- Busy length:
  - steps×(PULSE_CYCLES+GAP_CYCLES) cycles.
  - Add (RST_CYCLES+GAP_CYCLES) when CMD_RESET=1.
  - DONE follows in the next cycle; CMD_READY=1 the cycle after DONE.
- steps=0 and CMD_RESET=0: DONE in cycle 1, CMD_READY in cycle 2.
- The downstream driver adds one register stage. External pins lag requests by one cycle; widths are preserved.
- Minimum pulse at 100 MHz is 10 ns, which meets the counter IC's 5 ns minimum width.

## Test plan
- Reset: hold RST 3 cycles → all outputs at reset values, CMD_READY=1.
- Defaults, steps=3, CMD_RESET=0 → ADVANCE_COUNTER high in cycles 1-2, 5-6 and 9-10, low otherwise. DONE in cycle 13, POSITION=3, ABORTED=0.
- CMD_RESET=1, steps=1, POSITION=7 beforehand → RESET_COUNTER high in cycles 1-4 and POSITION=0 from cycle 1. ADVANCE_COUNTER high in cycles 7-8, DONE in cycle 11, POSITION=1.
- COUNT_W=4, POSITION=14, steps=3 → POSITION goes 15, 0, 1. No overlap of ADVANCE_COUNTER and RESET_COUNTER in any cycle (assertion).
- ABORT in cycle 6 of a steps=5 command → requests low from cycle 7, DONE with ABORTED=1 in cycle 9, POSITION=2.
- steps=0, CMD_RESET=0 → DONE in cycle 1, no requests ever raised. CMD_VALID held during a busy command → no second acceptance until CMD_READY returns.

Source files
------------

// File: rtl/counter_seq.sv
// Command sequencer ahead of the counter-IC driver: turns "reset and/or advance N steps"
// into timed RESET_COUNTER / ADVANCE_COUNTER requests and mirrors the counter position.
module counter_seq #(
    parameter int unsigned PULSE_CYCLES = 2,
    parameter int unsigned GAP_CYCLES   = 2,
    parameter int unsigned RST_CYCLES   = 4,
    parameter int unsigned COUNT_W      = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CMD_VALID,
    output logic               CMD_READY,
    input  logic               CMD_RESET,
    input  logic [COUNT_W-1:0] CMD_STEPS,
    input  logic               ABORT,
    output logic               ADVANCE_COUNTER,
    output logic               RESET_COUNTER,
    output logic               BUSY,
    output logic               DONE,
    output logic               ABORTED,
    output logic [COUNT_W-1:0] POSITION
);

    localparam int unsigned MaxPg     = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int unsigned MaxCycles = (MaxPg > RST_CYCLES) ? MaxPg : RST_CYCLES;
    localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

    localparam logic [CntW-1:0] PulseLast = CntW'(PULSE_CYCLES - 1);
    localparam logic [CntW-1:0] GapLast   = CntW'(GAP_CYCLES - 1);
    localparam logic [CntW-1:0] RstLast   = CntW'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRstPulse,
        StRstGap,
        StAdvPulse,
        StAdvGap,
        StAbortGap,
        StFinish
    } state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [COUNT_W-1:0] remaining_q, remaining_d;
    logic [COUNT_W-1:0] position_q, position_d;
    logic               adv_q, adv_d;
    logic               rst_req_q, rst_req_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               cnt_last;

    assign cnt_last = (cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        remaining_d = remaining_q;

        // cnt_q counts down the remaining cycles of the timed states
        case (state_q)
            StIdle: begin
                if (CMD_VALID) begin
                    remaining_d = CMD_STEPS;
                    if (CMD_RESET) begin
                        state_d = StRstPulse;
                        cnt_d   = RstLast;
                    end else if (CMD_STEPS != '0) begin
                        state_d     = StAdvPulse;
                        cnt_d       = PulseLast;
                        remaining_d = CMD_STEPS - 1'b1;
                    end else begin
                        state_d = StFinish;
                    end
                end
            end
            StRstPulse, StAdvPulse: begin
                if (cnt_last) begin
                    state_d = (state_q == StRstPulse) ? StRstGap : StAdvGap;
                    cnt_d   = GapLast;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StRstGap, StAdvGap: begin
                if (!cnt_last) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (remaining_q != '0) begin
                    state_d     = StAdvPulse;
                    cnt_d       = PulseLast;
                    remaining_d = remaining_q - 1'b1;
                end else begin
                    state_d = StFinish;
                end
            end
            StAbortGap: begin
                if (cnt_last) begin
                    state_d = StFinish;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        if (ABORT && (state_q inside {StRstPulse, StRstGap, StAdvPulse, StAdvGap})) begin
            state_d = StAbortGap;
            cnt_d   = GapLast;
        end

        // Outputs are decoded from the next state so they register with it
        adv_d     = (state_d == StAdvPulse);
        rst_req_d = (state_d == StRstPulse);
        done_d    = (state_d == StFinish);
        aborted_d = done_d && (state_q == StAbortGap);
        ready_d   = (state_d == StIdle);
        busy_d    = !ready_d && !done_d;

        position_d = position_q;
        if (rst_req_d && !rst_req_q) begin
            position_d = '0;
        end else if (adv_d && !adv_q) begin
            position_d = position_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            remaining_q <= '0;
            position_q  <= '0;
            adv_q       <= 1'b0;
            rst_req_q   <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            remaining_q <= remaining_d;
            position_q  <= position_d;
            adv_q       <= adv_d;
            rst_req_q   <= rst_req_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
        end
    end

    assign CMD_READY       = ready_q;
    assign ADVANCE_COUNTER = adv_q;
    assign RESET_COUNTER   = rst_req_q;
    assign BUSY            = busy_q;
    assign DONE            = done_q;
    assign ABORTED         = aborted_q;
    assign POSITION        = position_q;

endmodule

// File: tb/tb_counter_seq.sv
// Scoreboard bench for counter_seq: a 16-bit and a 4-bit instance share the same stimulus.
module tb_counter_seq;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CMD_VALID;
    logic        CMD_RESET;
    logic [15:0] CMD_STEPS;
    logic        ABORT;

    logic        cmd_ready, adv, rst_req, busy, done, aborted;
    logic [15:0] position;
    logic        cmd_ready4, adv4, rst_req4, busy4, done4, aborted4;
    logic [3:0]  position4;

    counter_seq dut (
        .CLK             (CLK),
        .RST             (RST),
        .CMD_VALID       (CMD_VALID),
        .CMD_READY       (cmd_ready),
        .CMD_RESET       (CMD_RESET),
        .CMD_STEPS       (CMD_STEPS),
        .ABORT           (ABORT),
        .ADVANCE_COUNTER (adv),
        .RESET_COUNTER   (rst_req),
        .BUSY            (busy),
        .DONE            (done),
        .ABORTED         (aborted),
        .POSITION        (position)
    );

    counter_seq #(.COUNT_W(4)) dut4 (
        .CLK             (CLK),
        .RST             (RST),
        .CMD_VALID       (CMD_VALID),
        .CMD_READY       (cmd_ready4),
        .CMD_RESET       (CMD_RESET),
        .CMD_STEPS       (CMD_STEPS[3:0]),
        .ABORT           (ABORT),
        .ADVANCE_COUNTER (adv4),
        .RESET_COUNTER   (rst_req4),
        .BUSY            (busy4),
        .DONE            (done4),
        .ABORTED         (aborted4),
        .POSITION        (position4)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int               done_cyc;
        int               kill_cyc;
        bit               aborted;
        logic [15:0]      pos16;
        logic [3:0]       pos4;
        bit               wave;
        logic [63:0]      adv_m;
        logic [63:0]      rst_m;
        logic [2:0][7:0]  pc;
        logic [2:0][15:0] pp16;
        logic [2:0][3:0]  pp4;
    } exp_t;

    exp_t q[$];
    int   ncmp = 0;
    int   nfail = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] rng(input int a, input int b);
        logic [63:0] m = '0;
        for (int i = a; i <= b; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic exp_t mk(input int dc, input bit ab, input logic [15:0] p16,
                                input logic [3:0] p4);
        exp_t e;
        e.done_cyc = dc;
        e.kill_cyc = 0;
        e.aborted  = ab;
        e.pos16    = p16;
        e.pos4     = p4;
        e.wave     = 1'b0;
        e.adv_m    = '0;
        e.rst_m    = '0;
        e.pc       = '0;
        e.pp16     = '0;
        e.pp4      = '0;
        return e;
    endfunction

    // Monitor: the head entry describes the command in flight; popped at its DONE cycle.
    int   rel = 0;
    bit   active = 1'b0;
    exp_t cur;

    always @(negedge CLK) begin
        if (mon_en) begin
            check("no_overlap", 32'(adv & rst_req), 32'(0));
            check("no_overlap4", 32'(adv4 & rst_req4), 32'(0));
            if (!active) begin
                check("idle_done", 32'(done), 32'(0));
                if (CMD_VALID && cmd_ready && !RST) begin
                    if (q.size() == 0) begin
                        ncmp++;
                        nfail++;
                        $display("FAIL accept: got an acceptance, expected none (t=%0t)", $time);
                    end else begin
                        cur    = q[0];
                        active = 1'b1;
                        rel    = 0;
                    end
                end
            end else begin
                rel++;
                if (q.size() == 0) begin
                    active = 1'b0;
                end else if (cur.kill_cyc != 0 && rel == cur.kill_cyc + 1) begin
                    check("kill_adv", 32'(adv), 32'(0));
                    check("kill_rst", 32'(rst_req), 32'(0));
                    check("kill_pos", 32'(position), 32'(0));
                    check("kill_pos4", 32'(position4), 32'(0));
                    check("kill_ready", 32'(cmd_ready), 32'(1));
                    check("kill_busy", 32'(busy), 32'(0));
                    check("kill_done", 32'(done), 32'(0));
                    cur    = q.pop_front();
                    active = 1'b0;
                end else begin
                    if (cur.wave) begin
                        check("adv", 32'(adv), 32'(cur.adv_m[rel]));
                        check("rst", 32'(rst_req), 32'(cur.rst_m[rel]));
                        check("adv4", 32'(adv4), 32'(cur.adv_m[rel]));
                        check("rst4", 32'(rst_req4), 32'(cur.rst_m[rel]));
                    end
                    check("busy", 32'(busy), 32'(rel < cur.done_cyc));
                    check("busy4", 32'(busy4), 32'(rel < cur.done_cyc));
                    check("ready", 32'(cmd_ready), 32'(0));
                    check("ready4", 32'(cmd_ready4), 32'(0));
                    for (int i = 0; i < 3; i++) begin
                        if (cur.pc[i] != 0 && rel == int'(cur.pc[i])) begin
                            check("probe_pos", 32'(position), 32'(cur.pp16[i]));
                            check("probe_pos4", 32'(position4), 32'(cur.pp4[i]));
                        end
                    end
                    if (rel == cur.done_cyc) begin
                        check("done", 32'(done), 32'(1));
                        check("done4", 32'(done4), 32'(1));
                        check("aborted", 32'(aborted), 32'(cur.aborted));
                        check("aborted4", 32'(aborted4), 32'(cur.aborted));
                        check("final_pos", 32'(position), 32'(cur.pos16));
                        check("final_pos4", 32'(position4), 32'(cur.pos4));
                        cur    = q.pop_front();
                        active = 1'b0;
                    end else begin
                        check("done_early", 32'(done), 32'(0));
                    end
                end
            end
        end
    end

    task automatic wait_ready(input int limit);
        int n = 0;
        while (!cmd_ready && n < limit) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (!cmd_ready) begin
            ncmp++;
            nfail++;
            $display("FAIL ready_timeout: got CMD_READY=0, expected 1 within %0d cycles", limit);
        end
    endtask

    task automatic issue(input bit r, input logic [15:0] steps, input exp_t e);
        wait_ready(300);
        q.push_back(e);
        CMD_VALID = 1'b1;
        CMD_RESET = r;
        CMD_STEPS = steps;
        @(posedge CLK);
        #1;
        CMD_VALID = 1'b0;
        CMD_RESET = 1'b1;
        CMD_STEPS = 16'hA5A5;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((q.size() != 0 || !cmd_ready) && n < 400) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (q.size() != 0 || !cmd_ready) begin
            ncmp++;
            nfail++;
            $display("FAIL done_timeout: got %0d pending commands, expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish by t=100000");
        $fatal(1);
    end

    initial begin
        exp_t e;
        RST       = 1'b1;
        CMD_VALID = 1'b0;
        CMD_RESET = 1'b0;
        CMD_STEPS = '0;
        ABORT     = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_ready", 32'(cmd_ready), 32'(1));
        check("rst_adv", 32'(adv), 32'(0));
        check("rst_rst", 32'(rst_req), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_aborted", 32'(aborted), 32'(0));
        check("rst_pos", 32'(position), 32'(0));
        check("rst_pos4", 32'(position4), 32'(0));
        RST    = 1'b0;
        mon_en = 1'b1;

        // steps=3: pulses in 1-2, 5-6, 9-10, DONE in 13
        e = mk(13, 1'b0, 16'd3, 4'd3);
        e.wave  = 1'b1;
        e.adv_m = rng(1, 2) | rng(5, 6) | rng(9, 10);
        issue(1'b0, 16'd3, e);
        wait_done();

        e = mk(17, 1'b0, 16'd7, 4'd7);
        issue(1'b0, 16'd4, e);
        wait_done();

        // reset + 1 step from position 7
        e = mk(11, 1'b0, 16'd1, 4'd1);
        e.wave    = 1'b1;
        e.rst_m   = rng(1, 4);
        e.adv_m   = rng(7, 8);
        e.pc[0]   = 8'd1;
        e.pp16[0] = 16'd0;
        e.pp4[0]  = 4'd0;
        e.pc[1]   = 8'd7;
        e.pp16[1] = 16'd1;
        e.pp4[1]  = 4'd1;
        issue(1'b1, 16'd1, e);
        wait_done();

        e = mk(53, 1'b0, 16'd14, 4'd14);
        issue(1'b0, 16'd13, e);
        wait_done();

        // wrap of the 4-bit mirror: 15, 0, 1
        e = mk(13, 1'b0, 16'd17, 4'd1);
        e.wave    = 1'b1;
        e.adv_m   = rng(1, 2) | rng(5, 6) | rng(9, 10);
        e.pc[0]   = 8'd1;
        e.pp16[0] = 16'd15;
        e.pp4[0]  = 4'd15;
        e.pc[1]   = 8'd5;
        e.pp16[1] = 16'd16;
        e.pp4[1]  = 4'd0;
        e.pc[2]   = 8'd9;
        e.pp16[2] = 16'd17;
        e.pp4[2]  = 4'd1;
        issue(1'b0, 16'd3, e);
        wait_done();

        // abort in cycle 6 of a 5-step command
        e = mk(9, 1'b1, 16'd19, 4'd3);
        e.wave  = 1'b1;
        e.adv_m = rng(1, 2) | rng(5, 6);
        issue(1'b0, 16'd5, e);
        repeat (5) @(posedge CLK);
        #1;
        ABORT = 1'b1;
        @(posedge CLK);
        #1;
        ABORT = 1'b0;
        wait_done();

        // CMD_VALID held through a busy command; steps changed after acceptance
        e = mk(9, 1'b0, 16'd21, 4'd5);
        e.wave  = 1'b1;
        e.adv_m = rng(1, 2) | rng(5, 6);
        q.push_back(e);
        e = mk(1, 1'b0, 16'd21, 4'd5);
        e.wave = 1'b1;
        q.push_back(e);
        CMD_VALID = 1'b1;
        CMD_RESET = 1'b0;
        CMD_STEPS = 16'd2;
        @(posedge CLK);
        #1;
        CMD_STEPS = 16'd0;
        wait_ready(50);
        @(posedge CLK);
        #1;
        CMD_VALID = 1'b0;
        wait_done();

        // ABORT in IDLE is ignored
        ABORT = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            check("idle_abort_ready", 32'(cmd_ready), 32'(1));
            check("idle_abort_busy", 32'(busy), 32'(0));
        end

        // steps=0 with ABORT held through acceptance and FINISH: not aborted
        e = mk(1, 1'b0, 16'd21, 4'd5);
        e.wave = 1'b1;
        issue(1'b0, 16'd0, e);
        @(posedge CLK);
        #1;
        ABORT = 1'b0;
        wait_done();

        // RST mid-command: back to idle, no DONE
        e = mk(100, 1'b0, 16'd0, 4'd0);
        e.kill_cyc = 4;
        e.wave     = 1'b1;
        e.adv_m    = rng(1, 2);
        issue(1'b0, 16'd3, e);
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        wait_done();
        repeat (3) @(posedge CLK);
        #1;

        e = mk(5, 1'b0, 16'd1, 4'd1);
        e.wave  = 1'b1;
        e.adv_m = rng(1, 2);
        issue(1'b0, 16'd1, e);
        wait_done();
        repeat (2) @(posedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
        $finish;
    end

endmodule
